// File: rtl/irq_pending_latch.sv
// irq_pending_latch: front end of the 16-line interrupt path.
//
// Synchronises raw request lines, latches them per line (edge or level mode),
// presents the masked pending vector to an external priority encoder, captures
// the encoder index and offers it to the consumer with a valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_in_i     raw request lines, asynchronous to clk
//   edge_mode_i  per line: 1 = rising-edge latched, 0 = level
//   mask_i       per line: 1 = enabled
//   sw_clear_i   per line: clears pending bit and overflow flag
//   pend_vec_o   pending & mask, to encoder input (bit 15 = highest priority)
//   enc_y_i      encoder index, combinational from pend_vec_o
//   irq_valid_o  offered index is valid
//   irq_id_o     offered line index
//   irq_ready_i  consumer accepts the offer
//   overflow_o   sticky: an edge arrived while the line was already pending
module irq_pending_latch #(
    // Flops per synchroniser chain, legal range 2..4.
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req_in_i,
    input  logic [15:0] edge_mode_i,
    input  logic [15:0] mask_i,
    input  logic [15:0] sw_clear_i,
    output logic [15:0] pend_vec_o,
    input  logic [3:0]  enc_y_i,
    output logic        irq_valid_o,
    output logic [3:0]  irq_id_o,
    input  logic        irq_ready_i,
    output logic [15:0] overflow_o
);

    typedef enum logic [1:0] {StIdle, StOffer, StSettle} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0][15:0] sync_q;
    logic [15:0] sync;
    logic [15:0] prev_q;
    logic [15:0] pend_q, pend_d;
    logic [15:0] ovf_q, ovf_d;
    logic [3:0]  id_q, id_d;

    logic [15:0] rise;
    logic [15:0] ack_vec;
    logic [15:0] clr;
    logic [15:0] pend_edge;
    logic        ack;

    // Request synchroniser chains; stage 0 samples the raw lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= req_in_i;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            prev_q <= sync;
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        rise    = sync & ~prev_q;
        ack     = irq_valid_o & irq_ready_i;
        ack_vec = ack ? (16'h0001 << id_q) : 16'h0000;
        clr     = sw_clear_i | ack_vec;
        // Set beats clear for edge lines.
        pend_edge = rise | (pend_q & ~clr);
        pend_d    = (edge_mode_i & pend_edge) | (~edge_mode_i & sync);
        // Overflow only counts an edge that lands on a pending bit which survives.
        ovf_d = (edge_mode_i & rise & pend_q & ~clr) | (ovf_q & ~sw_clear_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            ovf_q  <= '0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign pend_vec_o = pend_q & mask_i;
    assign overflow_o = ovf_q;

    // Offer FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            StIdle: begin
                // enc_y_i is only meaningful for a nonzero pend_vec_o.
                if (|pend_vec_o) begin
                    id_d    = enc_y_i;
                    state_d = StOffer;
                end
            end
            StOffer: begin
                if (irq_ready_i) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                // Gives the cleared pend_vec_o and encoder a cycle to settle.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Valid decodes straight from state so reset drops it asynchronously.
    assign irq_valid_o = (state_q == StOffer);
    assign irq_id_o    = id_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Self-checking bench for irq_pending_latch: directed scenarios plus random
// stimulus, compared every cycle against a behavioural reference model.
module tb_irq_pending_latch;

    localparam int unsigned SyncStages = 2;

    logic        clk;
    logic        rst_n;
    logic [15:0] req_in, edge_mode, mask, sw_clear;
    logic [15:0] pend_vec, overflow;
    logic [3:0]  enc_y, irq_id;
    logic        irq_valid, irq_ready;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int          cyc      = 0;

    // Reference model state.
    logic [15:0] m_dly[$];
    logic [15:0] m_prev, m_pend, m_ovf;
    logic        m_valid;
    logic [3:0]  m_id;
    int          m_wait;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Priority encoder model: highest set bit wins.
    always_comb begin
        enc_y = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (pend_vec[i]) enc_y = 4'(i);
        end
    end

    irq_pending_latch #(.SYNC_STAGES(SyncStages)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_in_i    (req_in),
        .edge_mode_i (edge_mode),
        .mask_i      (mask),
        .sw_clear_i  (sw_clear),
        .pend_vec_o  (pend_vec),
        .enc_y_i     (enc_y),
        .irq_valid_o (irq_valid),
        .irq_id_o    (irq_id),
        .irq_ready_i (irq_ready),
        .overflow_o  (overflow)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [3:0] top_bit(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                r = 4'(i);
                break;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_dly.delete();
        for (int i = 0; i < int'(SyncStages); i++) m_dly.push_back(16'h0000);
        m_prev  = '0;
        m_pend  = '0;
        m_ovf   = '0;
        m_valid = 1'b0;
        m_id    = '0;
        m_wait  = 0;
    endtask

    // One clock edge of the specified behaviour, using the inputs seen at the edge.
    task automatic model_step();
        logic [15:0] s, rise, clr, pv, np, no;
        s = m_dly.pop_front();
        m_dly.push_back(req_in);
        rise = s & ~m_prev;
        pv   = m_pend & mask;
        clr  = sw_clear;
        if (m_valid && irq_ready) clr[m_id] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (edge_mode[i]) begin
                if (rise[i])     np[i] = 1'b1;
                else if (clr[i]) np[i] = 1'b0;
                else             np[i] = m_pend[i];
                if (rise[i] && m_pend[i] && !clr[i]) no[i] = 1'b1;
                else if (sw_clear[i])                no[i] = 1'b0;
                else                                 no[i] = m_ovf[i];
            end else begin
                np[i] = s[i];
                no[i] = sw_clear[i] ? 1'b0 : m_ovf[i];
            end
        end
        if (m_valid) begin
            if (irq_ready) begin
                m_valid = 1'b0;
                m_wait  = 1;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (pv != 16'h0000) begin
            m_valid = 1'b1;
            m_id    = top_bit(pv);
        end
        m_pend = np;
        m_ovf  = no;
        m_prev = s;
    endtask

    task automatic check_all();
        check_eq("pend_vec", pend_vec, m_pend & mask);
        check_eq("irq_valid", 16'(irq_valid), 16'(m_valid));
        check_eq("irq_id", 16'(irq_id), 16'(m_id));
        check_eq("overflow", overflow, m_ovf);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!irq_valid && n < budget) begin
            tick();
            n++;
        end
        check_eq({tag, "_wait"}, 16'(irq_valid), 16'd1);
    endtask

    int          first_cyc[$];
    logic [3:0]  first_id[$];
    logic        last_valid;

    initial begin
        rst_n     = 1'b1;
        req_in    = '0;
        edge_mode = '1;
        mask      = '1;
        sw_clear  = '0;
        irq_ready = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_pend", pend_vec, 16'h0000);
        check_eq("rst_valid", 16'(irq_valid), 16'd0);
        check_eq("rst_id", 16'(irq_id), 16'd0);
        check_eq("rst_ovf", overflow, 16'h0000);
        rst_n = 1'b1;
        tick();

        // Single edge on line 5: offer appears after the fourth edge.
        req_in[5] = 1'b1;
        repeat (4) tick();
        check_eq("s1_valid", 16'(irq_valid), 16'd1);
        check_eq("s1_id", 16'(irq_id), 16'd5);
        irq_ready = 1'b1;
        req_in    = '0;
        tick();
        check_eq("s1_clear", pend_vec, 16'h0000);
        repeat (4) tick();

        // Simultaneous edges on 3 and 12 under constant ready.
        req_in[3]  = 1'b1;
        req_in[12] = 1'b1;
        last_valid = 1'b0;
        repeat (12) begin
            tick();
            if (irq_valid && !last_valid) begin
                first_cyc.push_back(cyc);
                first_id.push_back(irq_id);
            end
            last_valid = irq_valid;
        end
        check_eq("s2_count", 16'(first_id.size()), 16'd2);
        if (first_id.size() == 2) begin
            check_eq("s2_first", 16'(first_id[0]), 16'd12);
            check_eq("s2_second", 16'(first_id[1]), 16'd3);
            check_eq("s2_spacing", 16'(first_cyc[1] - first_cyc[0]), 16'd3);
        end
        req_in = '0;
        repeat (6) tick();

        // Stall with a higher-priority arrival during the offer.
        irq_ready = 1'b0;
        req_in[2] = 1'b1;
        wait_valid("s3_first", 10);
        check_eq("s3_id", 16'(irq_id), 16'd2);
        req_in[15] = 1'b1;
        repeat (10) tick();
        check_eq("s3_hold_valid", 16'(irq_valid), 16'd1);
        check_eq("s3_hold_id", 16'(irq_id), 16'd2);
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
        wait_valid("s3_next", 6);
        check_eq("s3_next_id", 16'(irq_id), 16'd15);
        irq_ready = 1'b1;
        req_in    = '0;
        repeat (8) tick();

        // Overflow on line 7.
        irq_ready = 1'b0;
        req_in[7] = 1'b1;
        wait_valid("s4_first", 10);
        req_in[7] = 1'b0;
        repeat (3) tick();
        req_in[7] = 1'b1;
        repeat (4) tick();
        check_eq("s4_ovf_set", 16'(overflow[7]), 16'd1);
        check_eq("s4_single", pend_vec, 16'h0080);
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
        tick();
        check_eq("s4_acked", pend_vec, 16'h0000);
        sw_clear[7] = 1'b1;
        tick();
        sw_clear = '0;
        check_eq("s4_ovf_clr", overflow, 16'h0000);
        req_in = '0;
        repeat (6) tick();

        // Masked level line 9.
        edge_mode[9] = 1'b0;
        mask[9]      = 1'b0;
        req_in[9]    = 1'b1;
        repeat (6) tick();
        check_eq("s5_masked", pend_vec, 16'h0000);
        check_eq("s5_no_offer", 16'(irq_valid), 16'd0);
        mask[9] = 1'b1;
        wait_valid("s5_offer", 6);
        check_eq("s5_id", 16'(irq_id), 16'd9);
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
        wait_valid("s5_reoffer", 6);
        check_eq("s5_re_id", 16'(irq_id), 16'd9);
        req_in[9] = 1'b0;
        irq_ready = 1'b1;
        repeat (8) tick();
        check_eq("s5_dropped", 16'(irq_valid), 16'd0);
        edge_mode = '1;

        // Reset during an offer.
        irq_ready = 1'b0;
        req_in[4] = 1'b1;
        wait_valid("s6_offer", 10);
        #2 rst_n = 1'b0;
        #1;
        check_eq("s6_async_valid", 16'(irq_valid), 16'd0);
        check_eq("s6_async_pend", pend_vec, 16'h0000);
        model_reset();
        req_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) tick();
        check_eq("s6_quiet", 16'(irq_valid), 16'd0);

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 9) == 0) req_in[i] = ~req_in[i];
            end
            if ($urandom_range(0, 49) == 0) edge_mode = 16'($urandom);
            if ($urandom_range(0, 19) == 0) mask = 16'($urandom) | 16'($urandom);
            sw_clear = '0;
            if ($urandom_range(0, 7) == 0) sw_clear[$urandom_range(0, 15)] = 1'b1;
            irq_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
